cpu_checkpoint_collector: RTL and testbench
===========================================

Name: cpu_checkpoint_collector

Overview:
- Monitor-side receiver for a per-core checkpoint interrupt source.
- Detects each rising edge of the core's checkpoint IRQ and captures the core's 32-bit checkpoint word into a FIFO.
- Exposes the FIFO, status and control to the monitor CPU over an Avalon-MM slave.
- Raises an interrupt to the monitor while entries are pending.

Parameters:
- DEPTH, 16: FIFO entries; power of two, 2..256.
- PTR_W, 4: log2(DEPTH); set consistently with DEPTH.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- chk_data  input  32  checkpoint word from core (its register readback)
- chk_irq  input  1  checkpoint interrupt from core (register bit 8)
- avs_address  input  8  word address
- avs_write  input  1  Avalon write strobe
- avs_writedata  input  32  write data
- avs_read  input  1  Avalon read strobe
- avs_readdata  output  32  read data, combinational from avs_address and current state
- monitor_irq  output  1  interrupt to monitor CPU

Behaviour:
- Reset (synchronous on clk edge with reset=1):
  - FIFO empty, count=0, overflow=0, underflow=0, irq_enable=0.
  - chk_irq_d=1, so a level already high at reset release is not captured.
  - monitor_irq=0.
- Edge detect:
  - chk_irq_d registers chk_irq every cycle.
  - push = chk_irq & ~chk_irq_d.
  - chk_data is sampled in the same cycle as the push; it enters the FIFO at that edge.
- Pop: avs_read=1 with avs_address=0 and FIFO non-empty. The head is removed at that clock edge.
- Register map (word addresses; all others read 0 and ignore writes):
  - 0 DATA (R): head entry; 0 when empty.
  - 1 STATUS (R): [15:0] count, [16] empty, [17] full, [18] overflow, [19] underflow; rest 0.
  - 2 CONTROL (R/W):
    - [0] irq_enable, read/write.
    - Write-1 strobes, read back 0: [1] clear overflow, [2] clear underflow, [3] flush.
- Push/pop interaction:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop in the same cycle: both take effect; count unchanged. This holds when full (push accepted, no overflow) but not when empty (no pop, so count+1).
  - Push while full without pop: word dropped, overflow set, count stays DEPTH.
  - Read of address 0 while empty: returns 0, underflow set, no state change.
- Pointers: rd_ptr/wr_ptr are PTR_W bits, wrap DEPTH-1 -> 0. Count is PTR_W+1 bits.
- Flush:
  - Pointers and count return to 0.
  - A push in the same cycle as a flush is discarded.
  - Flags are unaffected.
- Clear vs set in the same cycle: a set event wins over a clear strobe.
- monitor_irq = irq_enable & (count != 0), driven from registered state with no extra latency. It deasserts in the cycle after the last pop.
- Writes to address 0 or 1 are ignored.
- Reset asserted mid-operation discards all FIFO contents and flags.

Optional Feature:
- Macro: CHECKPOINT_TIMESTAMP_EN.
- When defined:
  - A free-running 32-bit cycle counter runs, cleared by reset and wrapping at 2^32.
  - Its value is stored alongside each pushed word.
  - Address 3 TIMESTAMP (R) returns the timestamp of the current head entry; 0 when empty.
  - Software reads address 3 before popping via address 0.
- When undefined: no counter and no storage; address 3 reads 0.

Test Plan:
- Reset, then chk_data=0x00000155 and chk_irq 0->1 -> STATUS count=1, empty=0. Read addr0 -> 0x00000155. Next STATUS count=0, empty=1.
- chk_irq held high 5 cycles -> exactly one push. chk_irq high during and after reset release -> no push until a low->high transition.
- DEPTH=16, 17 pushes with no reads -> count=16, full=1, overflow=1. The 17th word is lost. Write CONTROL=0x2 -> overflow=0.
- FIFO full, push and addr0 read in the same cycle -> count stays 16, overflow=0. Order of the remaining data preserved.
- Read addr0 while empty -> readdata 0, underflow=1, count 0. Write CONTROL=0x4 clears it. Write CONTROL=0x1, push one -> monitor_irq=1. Pop -> monitor_irq=0 next cycle.
- Push 3 entries, write CONTROL=0x8 -> count=0, empty=1. With CHECKPOINT_TIMESTAMP_EN, pushes at counter values 10 and 25 -> addr3 returns 10, then 25 after one pop.

Source files
------------

// File: rtl/cpu_checkpoint_collector.sv
// cpu_checkpoint_collector: captures a core's checkpoint word into a FIFO on
// every rising edge of its checkpoint IRQ and exposes the FIFO, status and
// control over an Avalon-MM slave. Interrupts the monitor while entries wait.
// Optional build macro CHECKPOINT_TIMESTAMP_EN stores a 32-bit cycle stamp
// with each entry, readable at word address 3.
module cpu_checkpoint_collector #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] chk_data,
  input  logic        chk_irq,
  input  logic [7:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        monitor_irq
);

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;
  logic             overflow, underflow, irq_enable, chk_irq_d;

  logic push, pop_req, pop, empty, full, ctrl_wr, flush, push_ok, ov_set, uf_set;
  logic unused_wdata;

  assign unused_wdata = ^avs_writedata[31:4];

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign push    = chk_irq & ~chk_irq_d;
  assign pop_req = avs_read & (avs_address == 8'd0);
  assign pop     = pop_req & ~empty;
  assign ctrl_wr = avs_write & (avs_address == 8'd2);
  assign flush   = ctrl_wr & avs_writedata[3];
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push & (~full | pop) & ~flush;
  // A push discarded by flush is not an overflow.
  assign ov_set  = push & full & ~pop & ~flush;
  assign uf_set  = pop_req & empty;

  // Pointers, occupancy, flags and edge-detect history.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      irq_enable <= 1'b0;
      chk_irq_d  <= 1'b1;  // a level already high at release is not an edge
    end else begin
      chk_irq_d <= chk_irq;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        count <= count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
      end
      if (ctrl_wr) irq_enable <= avs_writedata[0];
      // Set events override same-cycle clear strobes.
      if (ov_set)                          overflow <= 1'b1;
      else if (ctrl_wr & avs_writedata[1]) overflow <= 1'b0;
      if (uf_set)                          underflow <= 1'b1;
      else if (ctrl_wr & avs_writedata[2]) underflow <= 1'b0;
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_ptr] <= chk_data;
  end

`ifdef CHECKPOINT_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] ts_mem [DEPTH];

  // Free-running cycle counter.
  always_ff @(posedge clk) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 32'd1;
  end

  // Stamp stored alongside each accepted word.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) ts_mem[wr_ptr] <= ts_cnt;
  end
`endif

  // Register read mux, combinational from address and current state.
  always_comb begin
    avs_readdata = '0;
    case (avs_address)
      8'd0: avs_readdata = empty ? 32'd0 : mem[rd_ptr];
      8'd1: avs_readdata = {12'd0, underflow, overflow, full, empty, 16'(count)};
      8'd2: avs_readdata = {31'd0, irq_enable};
`ifdef CHECKPOINT_TIMESTAMP_EN
      8'd3: avs_readdata = empty ? 32'd0 : ts_mem[rd_ptr];
`endif
      default: avs_readdata = '0;
    endcase
  end

  assign monitor_irq = irq_enable & ~empty;

endmodule

// File: tb/tb_cpu_checkpoint_collector.sv
// Self-checking bench for cpu_checkpoint_collector: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_cpu_checkpoint_collector;
  localparam int DEPTH = 16;
  localparam int PTR_W = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] chk_data = '0;
  logic        chk_irq = 1'b0;
  logic [7:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        monitor_irq;

  int checks = 0;
  int failures = 0;

  cpu_checkpoint_collector #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset), .chk_data(chk_data), .chk_irq(chk_irq),
    .avs_address(avs_address), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_read(avs_read),
    .avs_readdata(avs_readdata), .monitor_irq(monitor_irq)
  );

  always #5 clk = ~clk;

  // Cycles elapsed since reset release: the expected timestamp source.
  logic [31:0] cyc;
  always @(posedge clk) cyc <= reset ? 32'd0 : cyc + 32'd1;

  // Reference model: a queue of entries plus flag bits.
  typedef struct { logic [31:0] d; logic [31:0] t; } ent_t;
  ent_t q[$];
  bit m_ov, m_uf, m_en, m_prev;

  function automatic logic [31:0] exp_rd(input logic [7:0] a);
    int n;
    n = q.size();
    case (a)
      8'd0: return (n != 0) ? q[0].d : 32'd0;
      8'd1: return {12'd0, m_uf, m_ov, n == DEPTH, n == 0, 16'(n)};
      8'd2: return {31'd0, m_en};
`ifdef CHECKPOINT_TIMESTAMP_EN
      8'd3: return (n != 0) ? q[0].t : 32'd0;
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Apply one clock edge to the model from the current inputs, then advance.
  task automatic tick();
    bit push, pop_req, flush, ovs, ufs, do_pop;
    int n;
    ent_t e;
    if (reset) begin
      q.delete(); m_ov = 0; m_uf = 0; m_en = 0; m_prev = 1;
    end else begin
      push    = chk_irq && !m_prev;
      m_prev  = chk_irq;
      pop_req = avs_read && avs_address == 8'd0;
      flush   = avs_write && avs_address == 8'd2 && avs_writedata[3];
      n       = q.size();
      ufs     = pop_req && n == 0;
      ovs     = 0;
      if (flush) q.delete();
      else begin
        do_pop = pop_req && n > 0;
        ovs    = push && n == DEPTH && !do_pop;
        if (do_pop) void'(q.pop_front());
        if (push && !ovs) begin e.d = chk_data; e.t = cyc; q.push_back(e); end
      end
      if (avs_write && avs_address == 8'd2) begin
        m_en = avs_writedata[0];
        if (avs_writedata[1]) m_ov = 0;
        if (avs_writedata[2]) m_uf = 0;
      end
      if (ovs) m_ov = 1;
      if (ufs) m_uf = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    avs_read = 0; avs_write = 0; avs_writedata = '0; avs_address = 8'd1;
  endtask

  task automatic ctl_write(input logic [31:0] v);
    avs_address = 8'd2; avs_write = 1; avs_writedata = v;
    tick();
    idle();
  endtask

  task automatic pulse_push(input logic [31:0] d);
    chk_irq = 0; tick();
    chk_irq = 1; chk_data = d; tick();
  endtask

  task automatic test_reset();
    idle(); reset = 1; chk_irq = 1;
    tick(); tick();
    reset = 0;
    tick(); tick(); tick();
    avs_address = 8'd1; #1;
    checks++;
    if (avs_readdata !== 32'h0001_0000) begin failures++;
      $display("FAIL reset_status got=%h exp=%h", avs_readdata, 32'h0001_0000); end
    avs_address = 8'd2; #1;
    checks++;
    if (avs_readdata !== 32'h0 || monitor_irq !== 1'b0) begin failures++;
      $display("FAIL reset_ctrl_irq got=%h/%b exp=0/0", avs_readdata, monitor_irq); end
    idle();
  endtask

  task automatic test_basic();
    pulse_push(32'h0000_0155);
    for (int i = 0; i < 4; i++) tick();
    #1;
    checks++;
    if (avs_readdata !== 32'h0000_0001) begin failures++;
      $display("FAIL held_irq_one_push got=%h exp=%h", avs_readdata, 32'h1); end
    avs_address = 8'd0; avs_read = 1; #1;
    checks++;
    if (avs_readdata !== 32'h0000_0155) begin failures++;
      $display("FAIL basic_data got=%h exp=%h", avs_readdata, 32'h155); end
    tick(); idle(); #1;
    checks++;
    if (avs_readdata !== 32'h0001_0000) begin failures++;
      $display("FAIL basic_after_pop got=%h exp=%h", avs_readdata, 32'h0001_0000); end
  endtask

  task automatic test_overflow();
    logic [31:0] words[$];
    logic [31:0] w;
    for (int i = 0; i < 17; i++) begin
      w = $urandom; words.push_back(w); pulse_push(w);
    end
    #1;
    checks++;
    if (avs_readdata !== 32'h0006_0010) begin failures++;
      $display("FAIL overflow_status got=%h exp=%h", avs_readdata, 32'h0006_0010); end
    ctl_write(32'h2); #1;
    checks++;
    if (avs_readdata !== 32'h0002_0010) begin failures++;
      $display("FAIL overflow_clear got=%h exp=%h", avs_readdata, 32'h0002_0010); end
    // Full: push and pop in the same cycle.
    chk_irq = 0; tick();
    chk_irq = 1; chk_data = 32'hABCD_0001; avs_address = 8'd0; avs_read = 1; #1;
    checks++;
    if (avs_readdata !== words[0]) begin failures++;
      $display("FAIL full_pushpop_head got=%h exp=%h", avs_readdata, words[0]); end
    tick(); idle(); #1;
    checks++;
    if (avs_readdata !== 32'h0002_0010) begin failures++;
      $display("FAIL full_pushpop_status got=%h exp=%h", avs_readdata, 32'h0002_0010); end
    // Overflow set wins over a same-cycle clear.
    chk_irq = 0; tick();
    chk_irq = 1; avs_address = 8'd2; avs_write = 1; avs_writedata = 32'h2;
    tick(); idle(); #1;
    checks++;
    if (avs_readdata !== 32'h0006_0010) begin failures++;
      $display("FAIL set_wins_clear got=%h exp=%h", avs_readdata, 32'h0006_0010); end
    ctl_write(32'h2);
    void'(words.pop_front());
    words.pop_back();
    words.push_back(32'hABCD_0001);
    for (int i = 0; i < DEPTH; i++) begin
      avs_address = 8'd0; avs_read = 1; #1;
      checks++;
      if (avs_readdata !== words[i]) begin failures++;
        $display("FAIL drain_order[%0d] got=%h exp=%h", i, avs_readdata, words[i]); end
      tick();
    end
    idle(); #1;
    checks++;
    if (avs_readdata !== 32'h0001_0000) begin failures++;
      $display("FAIL drain_empty got=%h exp=%h", avs_readdata, 32'h0001_0000); end
  endtask

  task automatic test_underflow_irq();
    chk_irq = 0;
    avs_address = 8'd0; avs_read = 1; #1;
    checks++;
    if (avs_readdata !== 32'h0) begin failures++;
      $display("FAIL empty_read got=%h exp=0", avs_readdata); end
    tick(); idle(); #1;
    checks++;
    if (avs_readdata !== 32'h0009_0000) begin failures++;
      $display("FAIL underflow_status got=%h exp=%h", avs_readdata, 32'h0009_0000); end
    ctl_write(32'h4); #1;
    checks++;
    if (avs_readdata !== 32'h0001_0000) begin failures++;
      $display("FAIL underflow_clear got=%h exp=%h", avs_readdata, 32'h0001_0000); end
    ctl_write(32'h1);
    pulse_push(32'h1234_5678);
    checks++;
    if (monitor_irq !== 1'b1) begin failures++;
      $display("FAIL irq_assert got=%b exp=1", monitor_irq); end
    avs_address = 8'd0; avs_read = 1; tick(); idle();
    checks++;
    if (monitor_irq !== 1'b0) begin failures++;
      $display("FAIL irq_deassert got=%b exp=0", monitor_irq); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) pulse_push($urandom);
    ctl_write(32'h8); #1;
    checks++;
    if (avs_readdata !== 32'h0001_0000) begin failures++;
      $display("FAIL flush_status got=%h exp=%h", avs_readdata, 32'h0001_0000); end
    chk_irq = 0; tick();
    chk_irq = 1; avs_address = 8'd2; avs_write = 1; avs_writedata = 32'h8;
    tick(); idle(); #1;
    checks++;
    if (avs_readdata !== 32'h0001_0000) begin failures++;
      $display("FAIL flush_drops_push got=%h exp=%h", avs_readdata, 32'h0001_0000); end
  endtask

  task automatic test_timestamp();
    logic [31:0] e1, e2;
    idle(); chk_irq = 0; reset = 1; tick(); reset = 0;
    for (int i = 0; i < 40 && cyc != 32'd10; i++) tick();
    chk_irq = 1; tick(); chk_irq = 0;
    for (int i = 0; i < 40 && cyc != 32'd25; i++) tick();
    chk_irq = 1; tick(); chk_irq = 0;
`ifdef CHECKPOINT_TIMESTAMP_EN
    e1 = 32'd10; e2 = 32'd25;
`else
    e1 = 32'd0;  e2 = 32'd0;
`endif
    avs_address = 8'd3; #1;
    checks++;
    if (avs_readdata !== e1) begin failures++;
      $display("FAIL ts_first got=%0d exp=%0d", avs_readdata, e1); end
    avs_address = 8'd0; avs_read = 1; tick(); idle();
    avs_address = 8'd3; #1;
    checks++;
    if (avs_readdata !== e2) begin failures++;
      $display("FAIL ts_second got=%0d exp=%0d", avs_readdata, e2); end
    idle();
  endtask

  task automatic test_random();
    logic [7:0] addrs [6];
    addrs = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd255};
    for (int i = 0; i < 600; i++) begin
      chk_irq       = ($urandom_range(0, 1) == 1);
      chk_data      = $urandom;
      avs_address   = addrs[$urandom_range(0, 5)];
      avs_read      = ($urandom_range(0, 3) == 0);
      avs_write     = ($urandom_range(0, 9) == 0);
      avs_writedata = $urandom;
      if (avs_writedata[3] && $urandom_range(0, 3) != 0) avs_writedata[3] = 1'b0;
      reset         = (i == 400);
      #1;
      checks++;
      if (avs_readdata !== exp_rd(avs_address) || monitor_irq !== (m_en && q.size() != 0)) begin
        failures++;
        $display("FAIL random[%0d] addr=%0d got=%h/%b exp=%h/%b", i, avs_address,
                 avs_readdata, monitor_irq, exp_rd(avs_address), m_en && q.size() != 0);
      end
      tick();
    end
    reset = 0; idle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) pulse_push($urandom);
    ctl_write(32'h1);
    reset = 1; tick(); reset = 0; idle(); #1;
    checks++;
    if (avs_readdata !== 32'h0001_0000 || monitor_irq !== 1'b0) begin failures++;
      $display("FAIL reset_mid got=%h/%b exp=%h/0", avs_readdata, monitor_irq, 32'h0001_0000); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_underflow_irq();
    test_flush();
    test_timestamp();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
